bcd_down_counter: RTL

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_down_counter_if.sv | 27 ++
 rtl/bcd_nibble_adjust.sv | 29 ++
 rtl/bcd_down_counter.sv | 101 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared state encodings and BCD constants for the BCD down counter.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

   typedef enum logic [3:0] {
      IDLE            = 4'd0,
      READY           = 4'd1,
      EXAMINE_NIBBLES = 4'd3,
      UPDATE_OUTPUT   = 4'd4
   } state_t;

   localparam logic [3:0] BCD_NINE       = 4'd9;
   localparam logic [3:0] BCD_CORRECTION = 4'd6;

   // A one-digit counter still needs a one-bit index register.
   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter_if
// Brief    : Load/decrement request and count result bundle of the counter.
// Revision : 1.0
// ============================================================================
interface bcd_down_counter_if #(
   parameter int COUNTER_BITWIDTH = 24
);
   logic                        load;
   logic [COUNTER_BITWIDTH-1:0] loadValue;
   logic                        enable;
   logic                        ready;
   logic                        zero;
   logic [COUNTER_BITWIDTH-1:0] countValue;

   modport master (
      output load, loadValue, enable,
      input  ready, zero, countValue
   );

   modport slave (
      input  load, loadValue, enable,
      output ready, zero, countValue
   );
endinterface
`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
`default_nettype none
// ============================================================================
// Module   : bcd_nibble_adjust
// Brief    : Combinational fix-up of one nibble after a binary decrement.
// Revision : 1.0
// ============================================================================
module bcd_nibble_adjust
   import bcd_pkg::*;
#(
   parameter int COUNTER_BITWIDTH = 24,
   parameter int INDEX_WIDTH      = 3
) (
   input  logic [COUNTER_BITWIDTH-1:0] i_word,
   input  logic [INDEX_WIDTH-1:0]      i_index,
   output logic [COUNTER_BITWIDTH-1:0] o_word
);

   logic [INDEX_WIDTH+1:0]      w_shift;
   logic [3:0]                  w_nibble;
   logic [COUNTER_BITWIDTH-1:0] w_correction;

   // A borrowed nibble reads 0xF; subtracting 6 in place lands on 9 with no borrow out.
   assign w_shift      = {i_index, 2'b00};
   assign w_nibble     = i_word[w_shift +: 4];
   assign w_correction = COUNTER_BITWIDTH'(BCD_CORRECTION) << w_shift;
   assign o_word       = (w_nibble > BCD_NINE) ? (i_word - w_correction) : i_word;

endmodule
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter
// Brief    : Loadable BCD down counter; decrement is binary then per-nibble fix.
//            Define BCD_DOWN_COUNTER_WRAP_EN to wrap 0 to all nines.
// Revision : 1.0
// ============================================================================
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int COUNTER_DIGITS   = 6,
   parameter int COUNTER_BITWIDTH = COUNTER_DIGITS*4
) (
   input  logic                clock,
   input  logic                resetn,
   bcd_down_counter_if.slave   bus
);

   localparam int IDX_W = idx_width(COUNTER_DIGITS);
   localparam logic [IDX_W-1:0] c_last_index = IDX_W'(COUNTER_DIGITS - 1);
`ifdef BCD_DOWN_COUNTER_WRAP_EN
   localparam logic c_wrap_en = 1'b1;
`else
   localparam logic c_wrap_en = 1'b0;
`endif

   state_t                      r_state;
   logic                        r_ready;
   logic                        r_zero;
   logic [COUNTER_BITWIDTH-1:0] r_count;
   logic [COUNTER_BITWIDTH-1:0] r_work;
   logic [IDX_W-1:0]            r_index;
   logic [COUNTER_BITWIDTH-1:0] w_adjusted;

   bcd_nibble_adjust #(
      .COUNTER_BITWIDTH (COUNTER_BITWIDTH),
      .INDEX_WIDTH      (IDX_W)
   ) u_adjust (
      .i_word  (r_work),
      .i_index (r_index),
      .o_word  (w_adjusted)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_zero  <= 1'b1;
         r_count <= '0;
         r_work  <= '0;
         r_index <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!bus.enable) begin
                  r_state <= READY;
                  r_ready <= 1'b1;
               end
            end
            READY: begin
               if (bus.load) begin
                  r_work  <= bus.loadValue;
                  r_ready <= 1'b0;
                  r_state <= UPDATE_OUTPUT;
               end else if (bus.enable) begin
                  // Saturating build still walks the nibbles so latency matches.
                  if (c_wrap_en || (r_work != '0)) begin
                     r_work <= r_work - COUNTER_BITWIDTH'(1);
                  end
                  r_index <= '0;
                  r_ready <= 1'b0;
                  r_state <= EXAMINE_NIBBLES;
               end
            end
            EXAMINE_NIBBLES: begin
               r_work <= w_adjusted;
               if (r_index == c_last_index) begin
                  r_state <= UPDATE_OUTPUT;
               end else begin
                  r_index <= r_index + IDX_W'(1);
               end
            end
            UPDATE_OUTPUT: begin
               r_count <= r_work;
               r_zero  <= (r_work == '0);
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = r_ready;
   assign bus.zero       = r_zero;
   assign bus.countValue = r_count;

endmodule
`default_nettype wire
